// File: rtl/rsc_encoder_if.sv
// rsc_encoder_if: block-length load, bit input and mapped sample output bundle of the RSC encoder
interface rsc_encoder_if #(parameter int W = 16);
  logic [15:0] blklen;
  logic valid_blklen;
  logic in_bit;
  logic valid_in;
  logic ready;
  logic signed [W-1:0] sys_out;
  logic signed [W-1:0] par_out;
  logic valid_out;
  logic tail_out;
  logic last_out;
  logic err_blklen;
  modport master (
    output blklen, valid_blklen, in_bit, valid_in,
    input ready, sys_out, par_out, valid_out, tail_out, last_out, err_blklen
  );
  modport slave (
    input blklen, valid_blklen, in_bit, valid_in,
    output ready, sys_out, par_out, valid_out, tail_out, last_out, err_blklen
  );
endinterface

// File: rtl/rsc_encoder.sv
// rsc_encoder: LTE constituent RSC encoder (13/15 octal) with 3-step trellis termination and BPSK mapping
module rsc_encoder #(
  parameter int W    = 16,
  parameter int AMP  = 1024,
  parameter int KMIN = 40,
  parameter int KMAX = 6144
) (
  input logic clk,
  input logic rst,
  rsc_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  localparam logic signed [W-1:0] POS = W'(AMP);
  localparam logic signed [W-1:0] NEG = W'(-AMP);
  state_t state_q;
  logic [2:0] s_q, s_d;
  logic [12:0] cnt_q;
  logic [15:0] k_q;
  logic [1:0] tcnt_q;
  logic ready_q, valid_q, tail_q, last_q, err_q;
  logic signed [W-1:0] sys_q, par_q;
  logic u, fb, z, legal, acc;
  // in TAIL the input is chosen as s1^s2 so the feedback term cancels to zero
  always_comb begin
    u = (state_q == TAIL) ? (s_q[1] ^ s_q[2]) : bus.in_bit;
    fb = u ^ s_q[1] ^ s_q[2];
    z = fb ^ s_q[0] ^ s_q[2];
    s_d = {s_q[1:0], fb};
    legal = (bus.blklen >= 16'(KMIN)) && (bus.blklen <= 16'(KMAX));
    acc = bus.valid_in && ready_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      tcnt_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      tail_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      sys_q <= '0;
      par_q <= '0;
    end else begin
      valid_q <= 1'b0;
      tail_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.valid_blklen) begin
          if (legal) begin
            k_q <= bus.blklen;
            cnt_q <= '0;
            ready_q <= 1'b1;
            state_q <= DATA;
          end else err_q <= 1'b1;
        end
        DATA: if (acc) begin
          valid_q <= 1'b1;
          sys_q <= u ? NEG : POS;
          par_q <= z ? NEG : POS;
          s_q <= s_d;
          cnt_q <= cnt_q + 13'd1;
          if ({3'b0, cnt_q} == k_q - 16'd1) begin
            ready_q <= 1'b0;
            tcnt_q <= '0;
            state_q <= TAIL;
          end
        end
        TAIL: begin
          valid_q <= 1'b1;
          tail_q <= 1'b1;
          sys_q <= u ? NEG : POS;
          par_q <= z ? NEG : POS;
          s_q <= s_d;
          tcnt_q <= tcnt_q + 2'd1;
          if (tcnt_q == 2'd2) begin
            last_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ready = ready_q;
  assign bus.sys_out = sys_q;
  assign bus.par_out = par_q;
  assign bus.valid_out = valid_q;
  assign bus.tail_out = tail_q;
  assign bus.last_out = last_q;
  assign bus.err_blklen = err_q;
endmodule

// File: tb/tb_rsc_encoder.sv
// tb_rsc_encoder: random-stimulus bench against a feedback-sequence reference model of the RSC encoder
module tb_rsc_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rsc_encoder_if #(.W(16)) bus ();
  rsc_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int sys_q[$], par_q[$];
  bit tl_q[$], ls_q[$];
  bit ub[0:6143];
  bit ex_x[0:6146], ex_z[0:6146];
  always @(negedge clk) begin
    if (bus.valid_out) begin
      sys_q.push_back(int'(bus.sys_out));
      par_q.push_back(int'(bus.par_out));
      tl_q.push_back(bus.tail_out);
      ls_q.push_back(bus.last_out);
    end
    if (bus.err_blklen) err_cnt++;
  end
  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // a[n] is the feedback sequence: a = u / g0, parity = a * g1, tail picks u so a stays zero
  task automatic model(int k);
    bit a[0:6149];
    for (int i = 0; i < 3; i++) a[i] = 1'b0;
    for (int n = 0; n < k + 3; n++) begin
      bit u;
      if (n < k) begin
        u = ub[n];
        a[n+3] = u ^ a[n+1] ^ a[n];
      end else begin
        u = a[n+1] ^ a[n];
        a[n+3] = 1'b0;
      end
      ex_x[n] = u;
      ex_z[n] = a[n+3] ^ a[n+2] ^ a[n];
    end
  endtask
  task automatic clear_q();
    sys_q.delete(); par_q.delete(); tl_q.delete(); ls_q.delete();
    err_cnt = 0;
  endtask
  task automatic load(int k);
    bus.blklen = 16'(k);
    bus.valid_blklen = 1'b1;
    @(posedge clk); #1;
    bus.valid_blklen = 1'b0;
  endtask
  task automatic feed(int k, bit gap, bit inject, int stop, output int idx);
    int cyc = 0;
    bit acc, injected = 1'b0;
    idx = 0;
    while (idx < stop && cyc < 4 * k + 100) begin
      bus.valid_in = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_bit = ub[idx];
      if (inject && idx == 10 && !injected) begin
        bus.blklen = 16'd80;
        bus.valid_blklen = 1'b1;
        injected = 1'b1;
      end
      acc = bus.valid_in && bus.ready;
      @(posedge clk); #1;
      bus.valid_blklen = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    bus.valid_in = 1'b0;
  endtask
  task automatic check_block(string nm, int k);
    int w = 0;
    while (sys_q.size() < k + 3 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({nm, "_count"}, sys_q.size(), k + 3);
    for (int i = 0; i < k + 3 && i < sys_q.size(); i++) begin
      chk($sformatf("%s_sys[%0d]", nm, i), sys_q[i], ex_x[i] ? -1024 : 1024);
      chk($sformatf("%s_par[%0d]", nm, i), par_q[i], ex_z[i] ? -1024 : 1024);
      chk($sformatf("%s_tail[%0d]", nm, i), int'(tl_q[i]), int'(i >= k));
      chk($sformatf("%s_last[%0d]", nm, i), int'(ls_q[i]), int'(i == k + 2));
    end
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_final_state"}, int'(dut.s_q), 0);
  endtask
  task automatic run_block(string nm, int k, bit gap, bit inject);
    int idx;
    clear_q();
    model(k);
    load(k);
    feed(k, gap, inject, k, idx);
    chk({nm, "_accepted"}, idx, k);
    chk({nm, "_ready_drop"}, int'(bus.ready), 0);
    check_block(nm, k);
  endtask
  task automatic check_idle_outputs(string nm);
    chk({nm, "_ready"}, int'(bus.ready), 0);
    chk({nm, "_valid"}, int'(bus.valid_out), 0);
    chk({nm, "_sys"}, int'(bus.sys_out), 0);
    chk({nm, "_par"}, int'(bus.par_out), 0);
    chk({nm, "_tail"}, int'(bus.tail_out), 0);
    chk({nm, "_last"}, int'(bus.last_out), 0);
    chk({nm, "_err"}, int'(bus.err_blklen), 0);
  endtask
  initial begin
    int idx;
    int exp_par8[8] = '{1, 1, 1, 1, 0, 0, 1, 0};
    int exp_tx[3] = '{0, 0, 1};
    int exp_tz[3] = '{0, 1, 1};
    bus.blklen = '0;
    bus.valid_blklen = 1'b0;
    bus.in_bit = 1'b0;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6144; i++) ub[i] = 1'b0;
    run_block("zeros", 40, 1'b0, 1'b0);
    for (int i = 0; i < 43 && i < sys_q.size(); i++) begin
      chk($sformatf("zeros_abs_sys[%0d]", i), sys_q[i], 1024);
      chk($sformatf("zeros_abs_par[%0d]", i), par_q[i], 1024);
    end
    ub[0] = 1'b1;
    run_block("impulse", 40, 1'b0, 1'b0);
    for (int i = 0; i < 8 && i < par_q.size(); i++)
      chk($sformatf("impulse_abs_par[%0d]", i), par_q[i], exp_par8[i] ? -1024 : 1024);
    for (int i = 0; i < 3 && 40 + i < sys_q.size(); i++) begin
      chk($sformatf("impulse_tail_x[%0d]", i), sys_q[40+i], exp_tx[i] ? -1024 : 1024);
      chk($sformatf("impulse_tail_z[%0d]", i), par_q[40+i], exp_tz[i] ? -1024 : 1024);
    end
    for (int i = 0; i < 6144; i++) ub[i] = 1'($urandom_range(0, 1));
    run_block("kmax", 6144, 1'b1, 1'b0);
    clear_q();
    load(39);
    @(posedge clk); #1;
    load(6145);
    repeat (5) @(posedge clk);
    #1;
    chk("badlen_err_pulses", err_cnt, 2);
    chk("badlen_no_output", sys_q.size(), 0);
    chk("badlen_ready", int'(bus.ready), 0);
    for (int i = 0; i < 512; i++) ub[i] = 1'($urandom_range(0, 1));
    run_block("k512", 512, 1'b1, 1'b0);
    clear_q();
    load(512);
    feed(512, 1'b0, 1'b0, 100, idx);
    chk("abort_accepted", idx, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("abort");
    clear_q();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_tail", sys_q.size(), 0);
    for (int i = 0; i < 6144; i++) ub[i] = 1'b0;
    run_block("after_abort", 40, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) ub[i] = 1'($urandom_range(0, 1));
    run_block("reload_ignored", 40, 1'b1, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
